// File: rtl/duck_round_scheduler.sv
// ---------------------------------------------------------------------------
// duck_round_scheduler
//
// Sequences a Duck Hunt game session. A session is a series of rounds. Each
// round shows a "ROUND n" banner, then launches ducks one by one. Every duck
// is preceded by a pause. A duck either escapes after its flight time or is
// shot, and a shot duck falls for a fixed time. After the last duck of a round
// the hit count decides whether the game continues, is won, or is lost. All
// timers count frames (frame_tick_i strobes), never raw clocks.
//
// Ports
//   clk_i            system clock
//   rst_ni           asynchronous active-low reset
//   game_enable_i    level from game_control_fsm; low aborts the session
//   frame_tick_i     1-cycle strobe, once per video frame
//   duck_killed_i    1-cycle strobe from duck_game_logic on a hit
//   hunt_start_o     duck in flight
//   duck_falling_o   shot duck falling
//   show_banner_o    round banner visible
//   round_num_o      current round, 1-based (0 when idle)
//   duck_num_o       ducks launched this round
//   round_hits_o     hits this round
//   speed_level_o    min(round_num-1, 7), duck speed select
//   game_finished_o  high while the session has ended
//   game_won_o       valid with game_finished_o; 1 = all rounds passed
// ---------------------------------------------------------------------------
module duck_round_scheduler #(
    parameter int unsigned ROUNDS          = 5,
    parameter int unsigned DUCKS_PER_ROUND = 10,
    parameter int unsigned HITS_TO_PASS    = 6,
    parameter int unsigned BANNER_FRAMES   = 120,
    parameter int unsigned PAUSE_FRAMES    = 60,
    parameter int unsigned FLIGHT_FRAMES   = 300,
    parameter int unsigned FALL_FRAMES     = 45
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       game_enable_i,
    input  logic       frame_tick_i,
    input  logic       duck_killed_i,
    output logic       hunt_start_o,
    output logic       duck_falling_o,
    output logic       show_banner_o,
    output logic [3:0] round_num_o,
    output logic [3:0] duck_num_o,
    output logic [3:0] round_hits_o,
    output logic [2:0] speed_level_o,
    output logic       game_finished_o,
    output logic       game_won_o
);

    localparam int unsigned MAX_BP     = (BANNER_FRAMES > PAUSE_FRAMES) ? BANNER_FRAMES : PAUSE_FRAMES;
    localparam int unsigned MAX_FF     = (FLIGHT_FRAMES > FALL_FRAMES) ? FLIGHT_FRAMES : FALL_FRAMES;
    localparam int unsigned MAX_FRAMES = (MAX_BP > MAX_FF) ? MAX_BP : MAX_FF;
    localparam int unsigned CNT_W      = (MAX_FRAMES < 1) ? 1 : $clog2(MAX_FRAMES + 1);

    localparam logic [3:0] ROUNDS_L = 4'(ROUNDS);
    localparam logic [3:0] DUCKS_L  = 4'(DUCKS_PER_ROUND);
    localparam logic [3:0] HITS_L   = 4'(HITS_TO_PASS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BANNER,
        S_PAUSE,
        S_FLIGHT,
        S_FALL,
        S_ROUND_END,
        S_FINISHED
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         round_q, round_d;
    logic [3:0]         duck_q, duck_d;
    logic [3:0]         hits_q, hits_d;
    logic               won_q, won_d;
    logic [2:0]         speed_q, speed_d;
    logic               banner_q, hunt_q, falling_q, finished_q;
    logic [3:0]         round_m1;

    // A timed state ends on the tick that completes its frame budget, so the
    // state lasts exactly N ticks and that last tick is never credited to the
    // following state (the counter is cleared on every state change).
    function automatic logic timer_done(input logic tick, input logic [CNT_W-1:0] cnt,
                                        input int unsigned frames);
        return tick && ((32'(cnt) + 32'd1) >= frames);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        round_d = round_q;
        duck_d  = duck_q;
        hits_d  = hits_q;
        won_d   = won_q;

        if (frame_tick_i && (state_q == S_BANNER || state_q == S_PAUSE ||
                             state_q == S_FLIGHT || state_q == S_FALL)) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (!game_enable_i) begin
            state_d = S_IDLE;
            round_d = '0;
            duck_d  = '0;
            hits_d  = '0;
            won_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_BANNER;
                    round_d = 4'd1;
                    duck_d  = '0;
                    hits_d  = '0;
                    won_d   = 1'b0;
                end
                S_BANNER: begin
                    if (timer_done(frame_tick_i, cnt_q, BANNER_FRAMES)) state_d = S_PAUSE;
                end
                S_PAUSE: begin
                    if (timer_done(frame_tick_i, cnt_q, PAUSE_FRAMES)) begin
                        if (duck_q < DUCKS_L) begin
                            state_d = S_FLIGHT;
                            duck_d  = duck_q + 4'd1;
                        end else begin
                            state_d = S_ROUND_END;
                        end
                    end
                end
                S_FLIGHT: begin
                    // A kill arriving with the final flight tick still counts.
                    if (duck_killed_i) begin
                        state_d = S_FALL;
                        if (hits_q < duck_q) hits_d = hits_q + 4'd1;
                    end else if (timer_done(frame_tick_i, cnt_q, FLIGHT_FRAMES)) begin
                        state_d = S_PAUSE;
                    end
                end
                S_FALL: begin
                    if (timer_done(frame_tick_i, cnt_q, FALL_FRAMES)) state_d = S_PAUSE;
                end
                S_ROUND_END: begin
                    if (hits_q < HITS_L) begin
                        state_d = S_FINISHED;
                        won_d   = 1'b0;
                    end else if (round_q >= ROUNDS_L) begin
                        state_d = S_FINISHED;
                        won_d   = 1'b1;
                    end else begin
                        state_d = S_BANNER;
                        round_d = round_q + 4'd1;
                        duck_d  = '0;
                        hits_d  = '0;
                    end
                end
                S_FINISHED: begin
                    state_d = S_FINISHED;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        if (state_d != state_q) cnt_d = '0;
    end

    always_comb begin
        round_m1 = round_d - 4'd1;
        if (round_d == 4'd0) begin
            speed_d = '0;
        end else if (round_m1 > 4'd7) begin
            speed_d = 3'd7;
        end else begin
            speed_d = round_m1[2:0];
        end
    end

    // Status flags are registered from the next state so they line up with
    // the state register after each edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            round_q    <= '0;
            duck_q     <= '0;
            hits_q     <= '0;
            won_q      <= 1'b0;
            speed_q    <= '0;
            banner_q   <= 1'b0;
            hunt_q     <= 1'b0;
            falling_q  <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            round_q    <= round_d;
            duck_q     <= duck_d;
            hits_q     <= hits_d;
            won_q      <= won_d;
            speed_q    <= speed_d;
            banner_q   <= (state_d == S_BANNER);
            hunt_q     <= (state_d == S_FLIGHT);
            falling_q  <= (state_d == S_FALL);
            finished_q <= (state_d == S_FINISHED);
        end
    end

    assign hunt_start_o    = hunt_q;
    assign duck_falling_o  = falling_q;
    assign show_banner_o   = banner_q;
    assign round_num_o     = round_q;
    assign duck_num_o      = duck_q;
    assign round_hits_o    = hits_q;
    assign speed_level_o   = speed_q;
    assign game_finished_o = finished_q;
    assign game_won_o      = won_q;

endmodule
